// File: rtl/conv_transposed_2d_zero_stuffer.sv
// Zero-stuffs and zero-pads a raster-scan square feature map for a stride-1 transposed-conv backend.
// Latency: one register stage; a beat loaded on edge N is valid after edge N, 1 beat/cycle sustained.
// Backpressure: ready_out stalls the output register; ready_in is high only at REAL positions with a free register.
module conv_transposed_2d_zero_stuffer #(
    parameter int DATA_W  = 32,
    parameter int IN_DIM  = 4,
    parameter int STRIDE  = 2,
    parameter int PAD     = 2,
    parameter int OUT_PAD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] input_data,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] output_data,
    output logic              sof_out,
    output logic              eof_out
);

    localparam int OUT_DIM = (IN_DIM - 1) * STRIDE + 1 + 2 * PAD + OUT_PAD;
    localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    // Offset from the first REAL index to the last REAL index along one axis.
    localparam int SPAN    = (IN_DIM - 1) * STRIDE;

    localparam logic [CW-1:0] LAST_IDX = CW'(OUT_DIM - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [PW-1:0] row_ph;
    logic [PW-1:0] col_ph;

    int   row_off;
    int   col_off;
    logic row_real;
    logic col_real;
    logic pos_real;
    logic can_load;
    logic load;
    logic at_last_col;
    logic at_last_row;

    // Phase follows (idx - PAD) mod STRIDE; it is pinned at 0 while idx is still
    // inside the leading pad, so it reads 0 exactly when idx reaches PAD.
    function automatic logic [PW-1:0] ph_next(input int off, input logic [PW-1:0] ph);
        if (off < 0) begin
            return '0;
        end
        return (ph == PH_LAST) ? '0 : ph + 1'b1;
    endfunction

    // Classify the position about to be loaded and derive the handshake.
    always_comb begin
        row_off     = int'({1'b0, row}) - PAD;
        col_off     = int'({1'b0, col}) - PAD;
        row_real    = (row_off >= 0) && (row_off <= SPAN) && (row_ph == '0);
        col_real    = (col_off >= 0) && (col_off <= SPAN) && (col_ph == '0);
        pos_real    = row_real && col_real;
        at_last_col = (col == LAST_IDX);
        at_last_row = (row == LAST_IDX);
        can_load    = !valid_out || ready_out;
        // A REAL slot only fills from a real sample; ZERO slots never touch the input.
        ready_in    = rst_n && pos_real && can_load;
        load        = can_load && (!pos_real || valid_in);
    end

    // Output register, position counters and phase counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            output_data <= '0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
            row         <= '0;
            col         <= '0;
            row_ph      <= '0;
            col_ph      <= '0;
        end else if (load) begin
            valid_out   <= 1'b1;
            output_data <= pos_real ? input_data : '0;
            sof_out     <= (row == '0) && (col == '0);
            eof_out     <= at_last_row && at_last_col;
            if (at_last_col) begin
                col    <= '0;
                col_ph <= '0;
                if (at_last_row) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row    <= row + 1'b1;
                    row_ph <= ph_next(row_off, row_ph);
                end
            end else begin
                col    <= col + 1'b1;
                col_ph <= ph_next(col_off, col_ph);
            end
        end else if (ready_out) begin
            // Current beat drained and nothing replaced it (REAL slot, no sample yet).
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_transposed_2d_zero_stuffer.sv
module tb_conv_transposed_2d_zero_stuffer;

    // Three configurations: default, pass-through, and default with OUT_PAD=1.
    localparam int C_IN [3] = '{4, 4, 4};
    localparam int C_S  [3] = '{2, 1, 2};
    localparam int C_P  [3] = '{2, 0, 2};
    localparam int C_OP [3] = '{0, 0, 1};

    logic        clk;
    logic        rst_n;
    logic        vi  [3];
    logic        ri  [3];
    logic [31:0] di  [3];
    logic        vo  [3];
    logic        ro  [3];
    logic [31:0] dout[3];
    logic        so  [3];
    logic        eo  [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] smp[$];

    // run statistics
    int beats, in_fires, bubbles, bubble_pos, first_acc, cyc;

    conv_transposed_2d_zero_stuffer #(.DATA_W(32), .IN_DIM(4), .STRIDE(2), .PAD(2), .OUT_PAD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .valid_in(vi[0]), .ready_in(ri[0]), .input_data(di[0]),
        .valid_out(vo[0]), .ready_out(ro[0]), .output_data(dout[0]), .sof_out(so[0]), .eof_out(eo[0]));
    conv_transposed_2d_zero_stuffer #(.DATA_W(32), .IN_DIM(4), .STRIDE(1), .PAD(0), .OUT_PAD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .valid_in(vi[1]), .ready_in(ri[1]), .input_data(di[1]),
        .valid_out(vo[1]), .ready_out(ro[1]), .output_data(dout[1]), .sof_out(so[1]), .eof_out(eo[1]));
    conv_transposed_2d_zero_stuffer #(.DATA_W(32), .IN_DIM(4), .STRIDE(2), .PAD(2), .OUT_PAD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .valid_in(vi[2]), .ready_in(ri[2]), .input_data(di[2]),
        .valid_out(vo[2]), .ready_out(ro[2]), .output_data(dout[2]), .sof_out(so[2]), .eof_out(eo[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int od_of(input int sel);
        return (C_IN[sel] - 1) * C_S[sel] + 1 + 2 * C_P[sel] + C_OP[sel];
    endfunction

    // Reference: beat k of the stream, computed directly from output coordinates.
    // Returns {sof, eof, data}.
    function automatic logic [33:0] model(input int sel, input int k);
        int od, od2, f, p, r, c, rr, cc, n;
        bit is_real;
        logic [31:0] d;
        od  = od_of(sel);
        od2 = od * od;
        n   = C_IN[sel];
        f   = k / od2;
        p   = k % od2;
        r   = p / od;
        c   = p % od;
        rr  = r - C_P[sel];
        cc  = c - C_P[sel];
        is_real = (rr >= 0) && (cc >= 0) && (rr % C_S[sel] == 0) && (cc % C_S[sel] == 0)
                  && (rr / C_S[sel] < n) && (cc / C_S[sel] < n);
        d = is_real ? smp[f * n * n + (rr / C_S[sel]) * n + cc / C_S[sel]] : 32'd0;
        return {p == 0, p == od2 - 1, d};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vi[i] = 1'b1;
            ro[i] = 1'b1;
        end
        #1;
        chk("rst_ready_in", 32'(ri[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", 32'(vo[0]), 32'd0);
        chk("rst_data", dout[0], 32'd0);
        chk("rst_sof", 32'(so[0]), 32'd0);
        chk("rst_eof", 32'(eo[0]), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vi[i] = 1'b0;
            ro[i] = 1'b0;
        end
    endtask

    // mode 0: all high; 1: ready_out alternates 1,0; 2: valid drop before sample 6; 3: random.
    task automatic run(input int sel, input int nframes, input int mode, input bit seq, input int max_beats);
        int n2, total, target, budget, in_idx, drop;
        bit stalled;
        logic [31:0] sv_d;
        logic sv_s, sv_e;
        logic [33:0] e;
        n2     = C_IN[sel] * C_IN[sel];
        total  = nframes * od_of(sel) * od_of(sel);
        target = (max_beats > 0 && max_beats < total) ? max_beats : total;
        budget = total * 6 + 100;
        smp.delete();
        for (int i = 0; i < nframes * n2; i++)
            smp.push_back(seq ? 32'(i % n2 + 1) : $urandom);
        beats = 0; in_fires = 0; bubbles = 0; bubble_pos = -1; first_acc = -1; cyc = 0;
        in_idx = 0; drop = 0; stalled = 1'b0;
        sv_d = '0; sv_s = 1'b0; sv_e = 1'b0;
        while (beats < target && cyc < budget) begin
            case (mode)
                1:       ro[sel] = (cyc % 2 == 0);
                3:       ro[sel] = ($urandom_range(0, 3) != 0);
                default: ro[sel] = 1'b1;
            endcase
            vi[sel] = (in_idx < nframes * n2);
            if (mode == 2 && in_idx == 5 && drop < 3) begin
                vi[sel] = 1'b0;
                drop++;
            end
            if (mode == 3 && $urandom_range(0, 2) == 0) vi[sel] = 1'b0;
            di[sel] = vi[sel] ? smp[in_idx] : $urandom;
            #1;
            if (stalled) begin
                chk("stall_data", dout[sel], sv_d);
                chk("stall_sof", 32'(so[sel]), 32'(sv_s));
                chk("stall_eof", 32'(eo[sel]), 32'(sv_e));
            end
            stalled = vo[sel] && !ro[sel];
            if (stalled) begin
                chk("stall_ready_in", 32'(ri[sel]), 32'd0);
                sv_d = dout[sel]; sv_s = so[sel]; sv_e = eo[sel];
            end
            if (!vo[sel] && beats > 0) begin
                bubbles++;
                bubble_pos = beats;
            end
            if (vo[sel] && ro[sel]) begin
                e = model(sel, beats);
                chk("beat_data", dout[sel], e[31:0]);
                chk("beat_sof", 32'(so[sel]), 32'(e[33]));
                chk("beat_eof", 32'(eo[sel]), 32'(e[32]));
                beats++;
            end
            if (vi[sel] && ri[sel]) begin
                in_idx++;
                in_fires++;
                if (first_acc < 0) first_acc = cyc;
            end
            cyc++;
            @(negedge clk);
        end
        vi[sel] = 1'b0;
        ro[sel] = 1'b0;
        if (beats < target) chk("timeout_beats", 32'(beats), 32'(target));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vi[i] = 1'b0; ro[i] = 1'b0; di[i] = '0;
        end

        // Two back-to-back default frames of 1..16, everything held high.
        do_reset();
        run(0, 2, 0, 1'b1, 0);
        chk("s1_inputs", 32'(in_fires), 32'd32);
        chk("s1_bubbles", 32'(bubbles), 32'd0);
        chk("s1_first_accept", 32'(first_acc), 32'd24);

        // Alternating ready_out.
        do_reset();
        run(0, 1, 1, 1'b1, 0);
        chk("s2_inputs", 32'(in_fires), 32'd16);

        // valid_in dropped ahead of sample 6: gap lands only before position (4,4).
        do_reset();
        run(0, 1, 2, 1'b1, 0);
        chk("s3_bubbles", 32'(bubbles), 32'd2);
        chk("s3_bubble_pos", 32'(bubble_pos), 32'd48);
        chk("s3_inputs", 32'(in_fires), 32'd16);

        // Reset after 30 beats, then a clean frame.
        do_reset();
        run(0, 1, 0, 1'b1, 30);
        do_reset();
        run(0, 1, 0, 1'b1, 0);
        chk("s5_inputs", 32'(in_fires), 32'd16);
        chk("s5_bubbles", 32'(bubbles), 32'd0);

        // Random traffic on the default configuration.
        do_reset();
        run(0, 3, 3, 1'b0, 0);
        chk("rnd0_inputs", 32'(in_fires), 32'd48);

        // Pass-through configuration.
        do_reset();
        run(1, 2, 0, 1'b1, 0);
        chk("pt_inputs", 32'(in_fires), 32'd32);
        chk("pt_bubbles", 32'(bubbles), 32'd0);
        do_reset();
        run(1, 2, 3, 1'b0, 0);
        chk("pt_rnd_inputs", 32'(in_fires), 32'd32);

        // OUT_PAD=1: 12x12 output with zero row/col 11.
        do_reset();
        run(2, 2, 0, 1'b1, 0);
        chk("op_inputs", 32'(in_fires), 32'd32);
        chk("op_beats", 32'(beats), 32'd288);
        do_reset();
        run(2, 2, 3, 1'b0, 0);
        chk("op_rnd_inputs", 32'(in_fires), 32'd32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_transposed_2d_zero_stuffer.md
# conv_transposed_2d_zero_stuffer

Upstream front-end for the transposed-2D-convolution stage. Takes a square input feature map as a raster-scan stream of one sample per beat. Emits the zero-stuffed and zero-padded map: STRIDE-1 zeros between samples, PAD zeros around the border, OUT_PAD extra zeros at bottom/right. The downstream stage then computes the transposed convolution as an ordinary stride-1 convolution. Single channel per frame; channels and frames are sent back-to-back.

## Interface
- DATA_W, 32, sample width (opaque; zeros are all-zero words)
- IN_DIM, 4, input height = width; ≥1
- STRIDE, 2, transposed-conv stride; ≥1
- PAD, 2, border zeros per side (= kernel_size-1-padding); ≥0
- OUT_PAD, 0, extra zero rows/cols at bottom/right; 0 ≤ OUT_PAD < STRIDE
- Derived OUT_DIM = (IN_DIM-1)*STRIDE + 1 + 2*PAD + OUT_PAD (default 11)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- valid_in  in  1  input sample valid
- ready_in  out  1  input sample accepted when valid_in && ready_in
- input_data  in  DATA_W  input sample, raster order
- valid_out  out  1  output beat valid
- ready_out  in  1  downstream accepts beat when valid_out && ready_out
- output_data  out  DATA_W  stuffed/padded sample
- sof_out  out  1  high with beat at output (0,0)
- eof_out  out  1  high with beat at output (OUT_DIM-1, OUT_DIM-1)

## Operation
- Counters row, col index the next output position to load; width clog2(OUT_DIM). Phase counters track (row-PAD) mod STRIDE and (col-PAD) mod STRIDE. No dividers.
- Position is REAL iff row and col each satisfy: idx ≥ PAD, idx-PAD ≤ (IN_DIM-1)*STRIDE, and phase == 0. Otherwise the position is ZERO.
- One output register with a valid flag. can_load = !valid_out || ready_out.
- ZERO position and can_load: load output_data=0 and advance. Input is not consumed.
- REAL position: ready_in = can_load (combinational from ready_out). On valid_in && ready_in, load input_data and advance. If valid_in is low, nothing loads and valid_out drops after the current beat drains. A zero is never substituted for a missing sample.
- ready_in is 0 at every ZERO position, including when valid_in is high. The pending input waits.
- Advance: col increments. At col == OUT_DIM-1, col wraps to 0 and row increments. At the last position, row and col wrap to 0 and the next frame starts immediately.
- sof_out and eof_out are registered alongside output_data and describe the beat in the register.
- Exactly IN_DIM² inputs are consumed and OUT_DIM² beats emitted per frame.
- STRIDE=1, PAD=0, OUT_PAD=0: pure pass-through register stage.

## Timing
- Reset (rst_n low at a clock edge): valid_out=0, output_data=0, sof_out=0, eof_out=0, row=col=0, phases reset. ready_in is forced 0 while rst_n is low.
- Reset mid-frame discards the partial frame. The first post-reset beat is position (0,0) with sof_out=1.
- Latency: a load on edge N gives valid_out=1 after edge N. Throughput is 1 beat/cycle with ready_out held high.
- While valid_out && !ready_out, output_data, sof_out and eof_out hold stable and ready_in=0.
- Frame boundary: the eof beat is followed next cycle by the next frame's sof beat, with no bubble.

## Test plan
- Defaults, inputs 1..16, valid_in and ready_out held high -> 121 beats. (2,2)=1, (2,4)=2, (2,3)=0, (4,2)=5, (8,8)=16; the other 105 beats are zero. sof on beat 0, eof on beat 120. ready_in&&valid_in handshakes exactly 16 times; no bubbles.
- Same stimulus, ready_out alternating 1,0 -> identical 121-beat sequence. Data, sof and eof are stable across every stalled cycle; no input is accepted while stalled.
- Defaults, valid_in dropped for 3 cycles before sample 6 -> valid_out gaps appear only at REAL position (4,4). The sequence is unchanged and no extra zero is emitted.
- Defaults, sample 1 presented from cycle 0 -> ready_in stays low for the first 24 positions (rows 0-1 and row 2 cols 0-1), then accepts sample 1 at (2,2).
- rst_n low 2 cycles after 30 beats, then restart with inputs 1..16 -> valid_out=0 the cycle after reset. The next frame begins at (0,0) with sof_out=1 and matches the first scenario.
- STRIDE=1, PAD=0, OUT_PAD=0 -> 16 beats equal to the inputs in order, sof on 1, eof on 16. Then STRIDE=2, PAD=2, OUT_PAD=1 -> OUT_DIM=12 and row 11 and col 11 are all zero.
